// File: rtl/cam2_ctrl_pkg.sv
// Shared types for the cam2 sequencer: controller states and arbitration grant.
package cam2_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LK_REQ    = 3'd1,
    LK_RSP    = 3'd2,
    INS_PROBE = 3'd3,
    INS_CHK   = 3'd4,
    INS_WR    = 3'd5,
    FLUSH     = 3'd6
  } state_e;

  typedef enum logic {
    LK  = 1'b0,
    INS = 1'b1
  } grant_e;

endpackage

// File: rtl/cam2_victim_sel.sv
// Write-slot chooser: lowest free entry, otherwise the round-robin pointer.
// 'advance' tells the owner of rr_ptr to step it when this victim is used.
module cam2_victim_sel #(
  parameter int WORDS = 8,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic [WORDS-1:0] valid_map,
  input  logic [AW-1:0]    rr_ptr,
  output logic [AW-1:0]    victim,
  output logic             advance
);

  // Scan from the top down so the lowest free index is the last one kept
  always_comb begin
    victim  = rr_ptr;
    advance = 1'b1;
    for (int i = WORDS - 1; i >= 0; i--) begin
      victim  = valid_map[i] ? victim : AW'(i);
      advance = advance & valid_map[i];
    end
  end

endmodule

// File: rtl/cam2_ctrl.sv
// Sequencer/arbiter owning the single cam2 port: arbitrates lookup vs insert,
// probes for duplicate tags before writing, and flushes the CAM on command
// and after reset.
module cam2_ctrl
  import cam2_ctrl_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int TAG_SZ = 8,
  parameter int WORDS  = 8,
  parameter int AW     = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lk_valid,
  output logic              lk_ready,
  input  logic [TAG_SZ-1:0] lk_tag,
  output logic              lk_rsp_valid,
  output logic              lk_hit,
  output logic [BITS-1:0]   lk_data,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic [TAG_SZ-1:0] ins_tag,
  input  logic [BITS-1:0]   ins_data,
  output logic              ins_done,
  output logic              ins_dup,
  output logic [AW-1:0]     ins_addr,
  input  logic              flush,
  output logic              busy,
  output logic              cam_read,
  output logic [TAG_SZ-1:0] cam_check_tag,
  output logic              cam_write_,
  output logic [AW-1:0]     cam_w_addr,
  output logic [BITS-1:0]   cam_wdata,
  output logic [TAG_SZ-1:0] cam_new_tag,
  output logic              cam_new_valid,
  input  logic              cam_found_it,
  input  logic [BITS-1:0]   cam_data
);

  state_e            state;
  grant_e            last_grant;
  logic              flush_pend;
  logic [AW-1:0]     fl_cnt;
  logic [WORDS-1:0]  valid_map;
  logic [AW-1:0]     rr_ptr;
  logic [TAG_SZ-1:0] tag_q;
  logic [BITS-1:0]   data_q;

  logic              grant_lk;
  logic              grant_ins;
  logic [AW-1:0]     victim;
  logic              victim_adv;

  cam2_victim_sel #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_victim (
    .valid_map (valid_map),
    .rr_ptr    (rr_ptr),
    .victim    (victim),
    .advance   (victim_adv)
  );

  assign lk_ready  = (state == IDLE) && !flush_pend;
  assign ins_ready = (state == IDLE) && !flush_pend;
  assign busy      = (state != IDLE) || flush_pend;

  // Arbitration: on a tie the side that did not win last time gets the port
  always_comb begin
    grant_lk  = 1'b0;
    grant_ins = 1'b0;
    if (lk_valid && ins_valid) begin
      if (last_grant == INS) begin
        grant_lk = 1'b1;
      end else begin
        grant_ins = 1'b1;
      end
    end else if (lk_valid) begin
      grant_lk = 1'b1;
    end else if (ins_valid) begin
      grant_ins = 1'b1;
    end else begin
      grant_lk  = 1'b0;
      grant_ins = 1'b0;
    end
  end

  // Main sequencer: state, bookkeeping and registered result pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FLUSH;
      last_grant   <= INS;
      flush_pend   <= 1'b0;
      fl_cnt       <= '0;
      valid_map    <= '0;
      rr_ptr       <= '0;
      tag_q        <= '0;
      data_q       <= '0;
      lk_rsp_valid <= 1'b0;
      lk_hit       <= 1'b0;
      lk_data      <= '0;
      ins_done     <= 1'b0;
      ins_dup      <= 1'b0;
      ins_addr     <= '0;
    end else begin
      lk_rsp_valid <= 1'b0;
      ins_done     <= 1'b0;
      ins_dup      <= 1'b0;
      if (flush) begin
        flush_pend <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (flush_pend) begin
            // A flush arriving on this very edge stays pending for another pass
            state      <= FLUSH;
            fl_cnt     <= '0;
            flush_pend <= flush;
          end else if (grant_lk) begin
            state      <= LK_REQ;
            tag_q      <= lk_tag;
            last_grant <= LK;
          end else if (grant_ins) begin
            state      <= INS_PROBE;
            tag_q      <= ins_tag;
            data_q     <= ins_data;
            last_grant <= INS;
          end else begin
            state <= IDLE;
          end
        end
        LK_REQ: begin
          state <= LK_RSP;
        end
        LK_RSP: begin
          lk_rsp_valid <= 1'b1;
          lk_hit       <= cam_found_it;
          lk_data      <= cam_found_it ? cam_data : '0;
          state        <= IDLE;
        end
        INS_PROBE: begin
          state <= INS_CHK;
        end
        INS_CHK: begin
          if (cam_found_it) begin
            ins_done <= 1'b1;
            ins_dup  <= 1'b1;
            ins_addr <= '0;
            state    <= IDLE;
          end else begin
            state <= INS_WR;
          end
        end
        INS_WR: begin
          valid_map[victim] <= 1'b1;
          ins_done          <= 1'b1;
          ins_addr          <= victim;
          if (victim_adv) begin
            rr_ptr <= rr_ptr + AW'(1);
          end else begin
            rr_ptr <= rr_ptr;
          end
          state <= IDLE;
        end
        FLUSH: begin
          if (fl_cnt == AW'(WORDS - 1)) begin
            valid_map <= '0;
            rr_ptr    <= '0;
            fl_cnt    <= '0;
            state     <= IDLE;
          end else begin
            fl_cnt <= fl_cnt + AW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // CAM port decode: reads and writes come from disjoint states, never together
  always_comb begin
    cam_read      = 1'b0;
    cam_check_tag = tag_q;
    cam_write_    = 1'b1;
    cam_w_addr    = '0;
    cam_wdata     = '0;
    cam_new_tag   = '0;
    cam_new_valid = 1'b0;
    case (state)
      LK_REQ, INS_PROBE: begin
        cam_read = 1'b1;
      end
      INS_WR: begin
        cam_write_    = 1'b0;
        cam_w_addr    = victim;
        cam_wdata     = data_q;
        cam_new_tag   = tag_q;
        cam_new_valid = 1'b1;
      end
      FLUSH: begin
        cam_write_ = 1'b0;
        cam_w_addr = fl_cnt;
      end
      default: begin
        cam_read   = 1'b0;
        cam_write_ = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_cam2_ctrl.sv
// Directed bench for cam2_ctrl with a behavioural 8-entry cam2 model behind it.
module tb_cam2_ctrl;

  logic       clk;
  logic       rst;
  logic       lk_valid, lk_ready, lk_rsp_valid, lk_hit;
  logic [7:0] lk_tag, lk_data;
  logic       ins_valid, ins_ready, ins_done, ins_dup;
  logic [7:0] ins_tag, ins_data;
  logic [2:0] ins_addr;
  logic       flush, busy;
  logic       cam_read, cam_write_, cam_new_valid, cam_found_it;
  logic [7:0] cam_check_tag, cam_wdata, cam_new_tag, cam_data;
  logic [2:0] cam_w_addr;

  int tests = 0;
  int fails = 0;
  logic overlap_seen = 1'b0;

  cam2_ctrl #(.BITS(8), .TAG_SZ(8), .WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_tag(lk_tag),
    .lk_rsp_valid(lk_rsp_valid), .lk_hit(lk_hit), .lk_data(lk_data),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_tag(ins_tag), .ins_data(ins_data),
    .ins_done(ins_done), .ins_dup(ins_dup), .ins_addr(ins_addr),
    .flush(flush), .busy(busy),
    .cam_read(cam_read), .cam_check_tag(cam_check_tag), .cam_write_(cam_write_),
    .cam_w_addr(cam_w_addr), .cam_wdata(cam_wdata), .cam_new_tag(cam_new_tag),
    .cam_new_valid(cam_new_valid), .cam_found_it(cam_found_it), .cam_data(cam_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cam2 model: {valid, tag, data} per entry, read result registered
  logic [16:0] cam_mem [8];

  function automatic logic [8:0] cam_search(input logic [7:0] t);
    logic [8:0] r;
    r = 9'd0;
    for (int i = 0; i < 8; i++) begin
      if (cam_mem[i][16] && cam_mem[i][15:8] == t) r = {1'b1, cam_mem[i][7:0]};
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) cam_mem[i] <= 17'd0;
      cam_found_it <= 1'b0;
      cam_data     <= 8'd0;
    end else begin
      if (!cam_write_) cam_mem[cam_w_addr] <= {cam_new_valid, cam_new_tag, cam_wdata};
      if (cam_read) begin
        cam_found_it <= cam_search(cam_check_tag) >> 8;
        cam_data     <= cam_search(cam_check_tag) & 9'h0FF;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && cam_read && !cam_write_) overlap_seen <= 1'b1;
  end

  typedef struct {
    bit         is_ins;
    logic [7:0] tag;
    logic [7:0] data;
    bit         exp_flag;   // insert: expect dup; lookup: expect hit
    logic [7:0] exp_data;
    logic [2:0] exp_addr;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic wait_ready(input bit for_ins, input int idx);
    int n = 0;
    while (!(for_ins ? ins_ready : lk_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", idx, (n < 200), 1);
  endtask

  task automatic do_insert(input vec_t v, input int idx);
    int n, wr;
    wait_ready(1'b1, idx);
    ins_valid = 1'b1; ins_tag = v.tag; ins_data = v.data;
    @(negedge clk);
    ins_valid = 1'b0;
    n = 1; wr = 0;
    while (!ins_done && n < 50) begin
      if (!cam_write_) wr++;
      @(negedge clk);
      n++;
    end
    check("ins_done", idx, ins_done, 1);
    check("ins_dup", idx, ins_dup, v.exp_flag);
    check("ins_addr", idx, ins_addr, v.exp_flag ? 3'd0 : v.exp_addr);
    check("ins_writes", idx, wr, v.exp_flag ? 0 : 1);
  endtask

  task automatic do_lookup(input vec_t v, input int idx);
    int n;
    wait_ready(1'b0, idx);
    lk_valid = 1'b1; lk_tag = v.tag;
    @(negedge clk);
    lk_valid = 1'b0;
    n = 1;
    while (!lk_rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("lk_latency", idx, n, 3);
    check("lk_hit", idx, lk_hit, v.exp_flag);
    check("lk_data", idx, lk_data, v.exp_data);
  endtask

  initial begin
    vec_t tmp;
    int n, fw, got;

    vecs[0]  = '{1'b1, 8'h05, 8'h11, 1'b0, 8'h00, 3'd0};
    vecs[1]  = '{1'b1, 8'h06, 8'h13, 1'b0, 8'h00, 3'd1};
    vecs[2]  = '{1'b1, 8'h09, 8'h17, 1'b0, 8'h00, 3'd2};
    vecs[3]  = '{1'b0, 8'h06, 8'h00, 1'b1, 8'h13, 3'd0};
    vecs[4]  = '{1'b1, 8'h05, 8'h55, 1'b1, 8'h00, 3'd0};
    vecs[5]  = '{1'b0, 8'h07, 8'h00, 1'b0, 8'h00, 3'd0};
    vecs[6]  = '{1'b1, 8'h0A, 8'h20, 1'b0, 8'h00, 3'd3};
    vecs[7]  = '{1'b1, 8'h0B, 8'h21, 1'b0, 8'h00, 3'd4};
    vecs[8]  = '{1'b1, 8'h0C, 8'h22, 1'b0, 8'h00, 3'd5};
    vecs[9]  = '{1'b1, 8'h0D, 8'h23, 1'b0, 8'h00, 3'd6};
    vecs[10] = '{1'b1, 8'h0E, 8'h24, 1'b0, 8'h00, 3'd7};
    vecs[11] = '{1'b1, 8'h0F, 8'h25, 1'b0, 8'h00, 3'd0};
    vecs[12] = '{1'b1, 8'h10, 8'h26, 1'b0, 8'h00, 3'd1};
    vecs[13] = '{1'b1, 8'h11, 8'h27, 1'b0, 8'h00, 3'd2};
    vecs[14] = '{1'b0, 8'h05, 8'h00, 1'b0, 8'h00, 3'd0};
    vecs[15] = '{1'b0, 8'h06, 8'h00, 1'b0, 8'h00, 3'd0};
    vecs[16] = '{1'b0, 8'h09, 8'h00, 1'b0, 8'h00, 3'd0};
    vecs[17] = '{1'b0, 8'h0F, 8'h00, 1'b1, 8'h25, 3'd0};
    vecs[18] = '{1'b0, 8'h0E, 8'h00, 1'b1, 8'h24, 3'd0};

    rst = 1'b1; lk_valid = 1'b0; ins_valid = 1'b0; flush = 1'b0;
    lk_tag = 8'h00; ins_tag = 8'h00; ins_data = 8'h00;

    // Reset edge, then exactly eight flush cycles walking the addresses
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_lk_rsp_valid", 0, lk_rsp_valid, 0);
    check("rst_ins_done", 0, ins_done, 0);
    check("rst_cam_read", 0, cam_read, 0);
    for (int i = 0; i < 8; i++) begin
      check("rst_busy", i, busy, 1);
      check("rst_flush_addr", i, cam_w_addr, i);
      check("rst_flush_write", i, cam_write_, 0);
      @(negedge clk);
    end
    check("post_rst_busy", 0, busy, 0);
    check("post_rst_lk_ready", 0, lk_ready, 1);
    check("post_rst_ins_ready", 0, ins_ready, 1);

    // Table of single-request operations
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].is_ins) do_insert(vecs[i], i);
      else do_lookup(vecs[i], i);
    end

    // Both requesters held high: last winner was a lookup, so INS first, then alternate
    lk_tag = 8'h30; ins_tag = 8'h30; ins_data = 8'h31;
    wait_ready(1'b0, 100);
    lk_valid = 1'b1; ins_valid = 1'b1;
    for (int g = 0; g < 8; g++) begin
      @(negedge clk);
      n = 1;
      while (!lk_rsp_valid && !ins_done && n < 50) begin
        @(negedge clk);
        n++;
      end
      got = lk_rsp_valid ? 0 : (ins_done ? 1 : 2);
      check("alt_grant", g, got, (g % 2 == 0) ? 1 : 0);
      if (got == 0) begin
        check("alt_lk_hit", g, lk_hit, 1);
        check("alt_lk_data", g, lk_data, 8'h31);
      end else if (got == 1) begin
        check("alt_ins_addr", g, ins_addr, (g == 0) ? 3'd3 : 3'd0);
      end
      if (g == 7) begin
        lk_valid = 1'b0; ins_valid = 1'b0;
      end
    end

    // Flush pulsed while an insert is in flight: insert completes, then 8 flush writes
    wait_ready(1'b1, 200);
    ins_valid = 1'b1; ins_tag = 8'h40; ins_data = 8'h41;
    @(negedge clk);
    ins_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n = 2;
    while (!ins_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_ins_done", 0, ins_done, 1);
    check("mid_ins_dup", 0, ins_dup, 0);
    check("mid_ins_addr", 0, ins_addr, 3'd4);
    check("mid_busy", 0, busy, 1);
    check("mid_lk_ready", 0, lk_ready, 0);
    fw = 0; n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
      if (!cam_write_ && !cam_new_valid) fw++;
    end
    check("mid_flush_writes", 0, fw, 8);
    check("mid_busy_end", 0, busy, 0);

    // Flush re-pulsed during FLUSH: a second full pass follows
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    fw = 0; n = 1;
    while (busy && n < 200) begin
      if (!cam_write_ && !cam_new_valid) fw++;
      flush = (n == 4);
      @(negedge clk);
      n++;
    end
    flush = 1'b0;
    check("dbl_flush_writes", 0, fw, 16);
    check("dbl_busy_end", 0, busy, 0);

    // Everything misses after the flush
    tmp = '{1'b0, 8'h30, 8'h00, 1'b0, 8'h00, 3'd0};
    do_lookup(tmp, 300);
    tmp.tag = 8'h40;
    do_lookup(tmp, 301);
    tmp.tag = 8'h0F;
    do_lookup(tmp, 302);

    check("no_read_write_overlap", 0, overlap_seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
